// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit: pipeline stage entry and forward-select encoding.
package hazard_pkg;

  // Entry rd field is sized for the widest supported register address; narrower
  // addresses are zero-extended on entry and on compare.
  localparam int unsigned RdMaxW = 16;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [RdMaxW-1:0] rd;
  } stage_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand dependency search over the tracked stages: youngest matching writer wins,
// and a too-young load raises a load-use stall request.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned SELW       = 2
) (
  input  stage_t [DEPTH:1]  ent,
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  output logic              load_stall,
  output logic [SELW-1:0]   sel
);

  always_comb begin
    load_stall = 1'b0;
    sel        = SELW'(FWD_RF);
    // Walk oldest to youngest so the lowest matching stage overrides older ones.
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (use_src && ent[k].valid && ent[k].wr && (ent[k].rd != '0) &&
          (ent[k].rd == RdMaxW'(src))) begin
        sel        = SELW'(k);
        load_stall = ent[k].load && (k < int'(LOAD_STAGE));
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and operand forwarding control for an in-order pipeline.
// Optional statistics counters (stall_cnt, fwd_cnt) are built when HAZARD_STATS_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned DEPTH      = 3,
  parameter  int unsigned LOAD_STAGE = 2,
  parameter  int unsigned REG_AW     = 5,
  localparam int unsigned SELW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              redirect,
  output logic              stall,
  output logic              issue,
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  stage_t [DEPTH:1] ent_q, ent_d;

  logic            stall_a, stall_b;
  logic [SELW-1:0] sel_a, sel_b;

  hazard_match #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .REG_AW     (REG_AW),
    .SELW       (SELW)
  ) u_match_rs (
    .ent        (ent_q),
    .src        (id_rs),
    .use_src    (id_use_rs),
    .load_stall (stall_a),
    .sel        (sel_a)
  );

  hazard_match #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .REG_AW     (REG_AW),
    .SELW       (SELW)
  ) u_match_rt (
    .ent        (ent_q),
    .src        (id_rt),
    .use_src    (id_use_rt),
    .load_stall (stall_b),
    .sel        (sel_b)
  );

  // A redirect squashes ID, so a pending load-use hazard no longer matters.
  always_comb begin
    stall = id_valid & ~redirect & (stall_a | stall_b);
    issue = id_valid & ~stall & ~redirect;
    fwd_a = stall ? SELW'(FWD_RF) : sel_a;
    fwd_b = stall ? SELW'(FWD_RF) : sel_b;
  end

  always_comb begin
    ent_d    = ent_q;
    ent_d[1] = '0;
    if (issue) begin
      ent_d[1] = '{valid: 1'b1, wr: id_wr, load: id_load, rd: RdMaxW'(id_rd)};
    end
    for (int k = 2; k <= int'(DEPTH); k++) begin
      ent_d[k] = ent_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (((fwd_a != '0) || (fwd_b != '0)) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, clr.
REQ-002 Parameter DEPTH, default 3, SHALL set the number of tracked stages after ID (1 = EX ... DEPTH = WB); legal range 2..8.
REQ-003 Parameter LOAD_STAGE, default 2, SHALL set the first stage whose load data is forwardable; legal range 1..DEPTH.
REQ-004 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-005 Derived constant SELW = clog2(DEPTH+1) SHALL set the forward-select width.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 clr  in  1  synchronous active-high reset.
REQ-008 id_valid  in  1  an instruction is present in ID.
REQ-009 id_rs, id_rt  in  REG_AW each  source register numbers.
REQ-010 id_use_rs, id_use_rt  in  1 each  the source is actually read.
REQ-011 id_rd  in  REG_AW  destination register number.
REQ-012 id_wr  in  1  the instruction writes the GPR file.
REQ-013 id_load  in  1  the instruction is a load.
REQ-014 redirect  in  1  a branch or jump resolved in ID squashes the instruction in ID.
REQ-015 stall  out  1  hold PC and IF/ID, and inject a bubble into EX.
REQ-016 issue  out  1  the ID instruction advances this cycle.
REQ-017 fwd_a, fwd_b  out  SELW each  operand source: 0 = register file, k = result of stage k.

Function
REQ-018 Tracking state SHALL be DEPTH registered entries {valid, rd, wr, load}; on each non-reset edge, entry k+1 SHALL take entry k, entry 1 SHALL take the ID instruction when issue=1 and a bubble otherwise, and entry DEPTH SHALL retire.
REQ-019 stall, issue, fwd_a and fwd_b SHALL be combinational from the state and the current inputs, with zero latency.
REQ-020 Entry k SHALL match a source when valid & wr & rd!=0 & rd==source & use; register 0 SHALL never match.
REQ-021 When several entries match, the lowest k (youngest) SHALL win; with no match, fwd SHALL be 0.
REQ-022 A winning entry with load=1 and k<LOAD_STAGE SHALL assert stall; otherwise fwd SHALL equal k.
REQ-023 A stall SHALL persist for LOAD_STAGE-k cycles and then release with fwd=LOAD_STAGE.
REQ-024 stall SHALL be 0 when id_valid=0.
REQ-025 issue SHALL equal id_valid & !stall & !redirect.
REQ-026 redirect together with a stall condition SHALL give stall=0 and insert a bubble into entry 1.
REQ-027 fwd outputs SHALL be 0 whenever stall=1.

Reset
REQ-028 On clr, every entry valid SHALL clear at the next edge; clr SHALL take priority over id_valid and redirect.
REQ-029 After reset, stall=0, issue=id_valid&!redirect, fwd_a=fwd_b=0.
REQ-030 clr asserted mid-stall SHALL end the stall in the following cycle.

Configuration
REQ-031 With macro HAZARD_STATS_EN defined, outputs stall_cnt and fwd_cnt (32 bits each, saturating, cleared by clr) SHALL count stall cycles and cycles in which any fwd is nonzero.
REQ-032 Without HAZARD_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-033 Package hazard_pkg SHALL hold the stage-entry typedef and the constant FWD_RF=0.
REQ-034 Sub-module hazard_match SHALL implement the per-operand priority match and load check, and SHALL be instantiated twice (rs, rt).

Verification (DEPTH=3, LOAD_STAGE=2)
REQ-035 addu r3 issued, then next instruction reads rs=r3 -> fwd_a=1, stall=0.
REQ-036 lw r5 issued, then next instruction reads rt=r5 -> stall=1 for one cycle, then fwd_b=2, issue=1.
REQ-037 Writer with rd=0, then reader of r0 -> fwd_a=0, stall=0.
REQ-038 r4 written by entries 1 and 2, then reader of r4 -> fwd_a=1.
REQ-039 lw r5, then load-use with redirect=1 -> stall=0, issue=0, entry 1 a bubble.
REQ-040 clr during a load-use stall -> next cycle stall=0, fwd=0; with HAZARD_STATS_EN, counters read 0.
